// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and an optional first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int AFULL_TH   = 12,
  parameter int AEMPTY_TH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      AFULL_C  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0]      AEMPTY_C = CNT_W'(AEMPTY_TH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  // Illegal parameterisations stop elaboration
  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must equal 1<<ADDR_WIDTH");
  end
  if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_bad_afull
    $error("sync_fifo_flags: AFULL_TH must lie in 1..DEPTH");
  end
  if ((AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : g_bad_aempty
    $error("sync_fifo_flags: AEMPTY_TH must lie in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_addr_s;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_nxt_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  afull_r;
  logic                  aempty_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [DATA_WIDTH-1:0] dout_r;
  logic [DATA_WIDTH-1:0] dout_nxt_s;

  // Accept decisions use only the registered full/empty of this cycle
  always_comb begin
    wr_acc_s = wr_en & ~full_r;
    rd_acc_s = rd_en & ~empty_r;
  end

  // Next occupancy
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Head address after this edge; FWFT bypasses din when writing into the new head slot
  always_comb begin
    rd_addr_s  = rd_ptr_r;
    dout_nxt_s = dout_r;
    if (rd_acc_s) begin
      rd_addr_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_addr_s = rd_ptr_r;
    end
    if (FWFT != 0) begin
      if (wr_acc_s && (wr_ptr_r == rd_addr_s)) begin
        dout_nxt_s = din;
      end else begin
        dout_nxt_s = mem_r[rd_addr_s];
      end
    end else if (rd_acc_s) begin
      dout_nxt_s = mem_r[rd_ptr_r];
    end else begin
      dout_nxt_s = dout_r;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy, status flags decoded from next count, and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      dout_r   <= '0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_addr_s;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == DEPTH_C);
      empty_r  <= (count_nxt_s == '0);
      afull_r  <= (count_nxt_s >= AFULL_C);
      aempty_r <= (count_nxt_s <= AEMPTY_C);
      dout_r   <= dout_nxt_s;
    end
  end

  // Sticky error flags: a new error in the same cycle as clr_err wins
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_en && full_r) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end
      if (rd_en && empty_r) begin
        underflow_r <= 1'b1;
      end else if (clr_err) begin
        underflow_r <= 1'b0;
      end
    end
  end

  assign dout         = dout_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = afull_r;
  assign almost_empty = aempty_r;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-read instance checked by a queue model plus
// scoreboard monitor, and an FWFT instance checked with directed vectors.
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b0, wr0 = 1'b0, rd0 = 1'b0, clr0 = 1'b0;
  logic [7:0] din0 = 8'h00;
  logic [7:0] dout0;
  logic [4:0] count0;
  logic       full0, empty0, af0, ae0, ov0, un0;

  logic       rst1 = 1'b1, wr1 = 1'b0, rd1 = 1'b0, clr1 = 1'b0;
  logic [7:0] din1 = 8'h00;
  logic [7:0] dout1;
  logic [4:0] count1;
  logic       full1, empty1, af1, ae1, ov1, un1;

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst0), .wr_en(wr0), .din(din0), .rd_en(rd0), .dout(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ov0), .underflow(un0), .clr_err(clr0)
  );

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst1), .wr_en(wr1), .din(din1), .rd_en(rd1), .dout(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ov1), .underflow(un1), .clr_err(clr1)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];   // expected read data, pushed at issue time
  logic [7:0] mq[$];      // reference FIFO contents
  bit         mov = 1'b0;
  bit         mun = 1'b0;
  bit         rd_expect = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("count", 32'(count0), 32'(n));
    chk("full", 32'(full0), 32'(n == 16));
    chk("empty", 32'(empty0), 32'(n == 0));
    chk("almost_full", 32'(af0), 32'(n >= 12));
    chk("almost_empty", 32'(ae0), 32'(n <= 4));
    chk("overflow", 32'(ov0), 32'(mov));
    chk("underflow", 32'(un0), 32'(mun));
  endtask

  // One clock of stimulus on dut0; the expected read word goes into the scoreboard
  task automatic cyc0(input bit w, input logic [7:0] d, input bit r, input bit c);
    bit fm, em;
    fm = (mq.size() == 16);
    em = (mq.size() == 0);
    wr0 = w; din0 = d; rd0 = r; clr0 = c;
    rd_expect = r && !em;
    if (r && !em) begin
      exp_q.push_back(mq[0]);
      mq.delete(0);
    end
    if (w && !fm) mq.push_back(d);
    if (w && fm) mov = 1'b1;
    else if (c) mov = 1'b0;
    if (r && em) mun = 1'b1;
    else if (c) mun = 1'b0;
    @(posedge clk); #1;
    wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0; rd_expect = 1'b0;
    check_model();
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    mq.delete();
    mov = 1'b0;
    mun = 1'b0;
    @(posedge clk); #1;
    rst0 = 1'b0;
    check_model();
    chk("dout_reset", 32'(dout0), 32'h0);
  endtask

  task automatic step1();
    @(posedge clk); #1;
    rst1 = 1'b0; wr1 = 1'b0; rd1 = 1'b0; clr1 = 1'b0;
  endtask

  // Scoreboard monitor: dout0 is valid one edge after an accepted read
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      if (rd_expect) begin
        #1;
        if (exp_q.size() == 0) begin
          chk("scoreboard_underrun", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("dout", 32'(dout0), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: fill 0x00..0x0F, watch threshold crossings
    reset0();
    for (int i = 0; i < 16; i++) begin
      cyc0(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 3)  chk("ae_after_4_writes", 32'(ae0), 32'd1);
      if (i == 4)  chk("ae_after_5_writes", 32'(ae0), 32'd0);
      if (i == 10) chk("af_after_11_writes", 32'(af0), 32'd0);
      if (i == 11) chk("af_after_12_writes", 32'(af0), 32'd1);
    end
    chk("full_after_16", 32'(full0), 32'd1);
    chk("count_after_16", 32'(count0), 32'd16);

    // 2: write while full, then drain
    cyc0(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("overflow_on_full_write", 32'(ov0), 32'd1);
    chk("count_held_16", 32'(count0), 32'd16);
    for (int i = 0; i < 16; i++) cyc0(1'b0, 8'h00, 1'b1, 1'b0);

    // 3: read while empty, then clear errors
    cyc0(1'b0, 8'h00, 1'b1, 1'b0);
    chk("underflow_on_empty_read", 32'(un0), 32'd1);
    chk("empty_after_drain", 32'(empty0), 32'd1);
    cyc0(1'b0, 8'h00, 1'b0, 1'b1);
    chk("overflow_cleared", 32'(ov0), 32'd0);
    chk("underflow_cleared", 32'(un0), 32'd0);

    // 4: prefill 8, then 20 simultaneous read/write cycles across the pointer wrap
    for (int i = 0; i < 8; i++) cyc0(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc0(1'b1, 8'(8'h55 + i), 1'b1, 1'b0);
      chk("count_steady_8", 32'(count0), 32'd8);
    end
    for (int i = 0; i < 8; i++) cyc0(1'b0, 8'h00, 1'b1, 1'b0);

    // 5: simultaneous read/write on a full FIFO
    for (int i = 0; i < 16; i++) cyc0(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    cyc0(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("count_full_rw", 32'(count0), 32'd15);
    chk("overflow_full_rw", 32'(ov0), 32'd1);
    reset0();

    // 6: FWFT instance
    rst1 = 1'b1;
    step1();
    chk("fwft_reset_count", 32'(count1), 32'd0);
    chk("fwft_reset_empty", 32'(empty1), 32'd1);
    wr1 = 1'b1; din1 = 8'hA5;
    step1();
    chk("fwft_first_word", 32'(dout1), 32'hA5);
    chk("fwft_not_empty", 32'(empty1), 32'd0);
    rd1 = 1'b1;
    step1();
    chk("fwft_empty_after_pop", 32'(empty1), 32'd1);
    rd1 = 1'b1;
    step1();
    chk("fwft_underflow", 32'(un1), 32'd1);
    for (int i = 0; i < 8; i++) begin
      wr1 = 1'b1; din1 = 8'(8'h30 + i);
      step1();
    end
    chk("fwft_head_0x30", 32'(dout1), 32'h30);
    chk("fwft_count_8", 32'(count1), 32'd8);
    rd1 = 1'b1;
    step1();
    chk("fwft_head_0x31", 32'(dout1), 32'h31);
    chk("fwft_count_7", 32'(count1), 32'd7);
    rst1 = 1'b1;
    step1();
    chk("fwft_midrst_count", 32'(count1), 32'd0);
    chk("fwft_midrst_empty", 32'(empty1), 32'd1);
    chk("fwft_midrst_aempty", 32'(ae1), 32'd1);
    chk("fwft_midrst_afull", 32'(af1), 32'd0);
    chk("fwft_midrst_full", 32'(full1), 32'd0);
    chk("fwft_midrst_underflow", 32'(un1), 32'd0);
    chk("fwft_midrst_overflow", 32'(ov1), 32'd0);
    wr1 = 1'b1; din1 = 8'h77;
    step1();
    chk("fwft_after_rst_word", 32'(dout1), 32'h77);
    chk("fwft_after_rst_count", 32'(count1), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
